// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter state encoding and
// elaboration-time helpers for baud divisor and counter width.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clock cycles per bit, rounded to nearest; 0 flags an unusable baud rate.
  function automatic int calc_div(input int clk_freq, input int baud);
    if (baud <= 0) return 0;
    return (clk_freq + baud / 2) / baud;
  endfunction

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 while enabled and flags the last cycle.
// PRELOAD lets a receiver start mid-bit for centre sampling.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV     = 2813,
  parameter int PRELOAD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = clog2(DIV);

  if (DIV < 2 || PRELOAD < 0 || PRELOAD >= DIV) begin : g_param_err
    $error("uart_baud_cnt: DIV must be >= 2 and 0 <= PRELOAD < DIV");
  end

  logic [CW-1:0] cnt_q;

  assign bit_end = en && (cnt_q == CW'(DIV - 1));

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours, avoiding sim/synth races.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= CW'(PRELOAD);
    end else if (en) begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, optional odd/even parity,
// 1-2 stop bits, valid/ready input and a frame-gated baud counter.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 27000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int DIV       = calc_div(CLK_FREQ, BAUD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int IDX_W = 4;

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $error("uart_tx_cfg: parameter out of range");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 txd_q, txd_d;
  logic                 par_d;
  logic                 accept;
  logic                 bit_end;

  // Ready and busy are pure state decodes, so tx_valid never reaches tx_ready.
  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = tx_ready && tx_valid;
  assign txd      = txd_q;

  uart_baud_cnt #(
    .DIV     (DIV),
    .PRELOAD (0)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .clr     (accept),
    .bit_end (bit_end)
  );

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          shift_d = tx_data;
          data_d  = tx_data;
          idx_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) state_d = ST_IDLE;
          else                                idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line level is decoded from the next state so txd can be a flop that
  // changes on exactly the same edge as the state.
  always_comb begin
    par_d = (^data_d) ^ (PARITY == PAR_ODD);
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: five configurations checked cycle by
// cycle against hand-written line patterns, plus streaming and reset cases.
module tb_uart_tx_cfg;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v    [NI];
  logic       tx_valid [NI];
  logic [8:0] tx_data  [NI];
  logic       txd_w    [NI];
  logic       ready_w  [NI];
  logic       busy_w   [NI];

  int divs [NI] = '{10, 10, 10, 10, 2813};
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic [11:0] line;   // line bits LSB first: start, data, parity, stop
    int         nbits;
  } vec_t;

  vec_t vecs [10];

  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst_v[0]), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(ready_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst_v[1]), .tx_data(tx_data[1][7:0]), .tx_valid(tx_valid[1]),
    .tx_ready(ready_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst_v[2]), .tx_data(tx_data[2][7:0]), .tx_valid(tx_valid[2]),
    .tx_ready(ready_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst_v[3]), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
    .tx_ready(ready_w[3]), .txd(txd_w[3]), .busy(busy_w[3]));
  uart_tx_cfg u_def (
    .clk(clk), .rst(rst_v[4]), .tx_data(tx_data[4][7:0]), .tx_valid(tx_valid[4]),
    .tx_ready(ready_w[4]), .txd(txd_w[4]), .busy(busy_w[4]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Returns at a falling edge with tx_ready high, or flags a timeout.
  task automatic wait_ready(input int inst, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (ready_w[inst] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_wait_ready"}, ready_w[inst], 1);
  endtask

  // Sends one frame and compares txd, busy and tx_ready on every cycle.
  // tx_valid stays high with different data during the frame; it must be ignored.
  task automatic send_frame(input int inst, input logic [8:0] data, input logic [11:0] line,
                            input int nbits, input string name);
    int len, bad, busy_cnt, rdy_cnt;
    len = nbits * divs[inst];
    bad = 0; busy_cnt = 0; rdy_cnt = 0;
    wait_ready(inst, name);
    tx_data[inst]  = data;
    tx_valid[inst] = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (txd_w[inst] !== line[(c - 1) / divs[inst]]) bad++;
      if (busy_w[inst] === 1'b1) busy_cnt++;
      if (ready_w[inst] !== 1'b0) rdy_cnt++;
      if (c == 1) tx_data[inst] = ~data;
      if (c == len - 5) tx_valid[inst] = 1'b0;
    end
    check({name, "_line_errs"}, bad, 0);
    check({name, "_busy_cycles"}, busy_cnt, len);
    check({name, "_ready_during"}, rdy_cnt, 0);
    @(negedge clk);
    check({name, "_end_ready"}, ready_w[inst], 1);
    check({name, "_end_busy"}, busy_w[inst], 0);
    check({name, "_end_txd"}, txd_w[inst], 1);
  endtask

  initial begin
    logic [9:0] l1, l2;
    logic       expb, exp_busy, rdy101;
    int         bad, bad_busy;

    vecs[0] = '{0, 9'h0A5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
    vecs[1] = '{0, 9'h000, {2'b00, 1'b1, 8'h00, 1'b0}, 10};
    vecs[2] = '{0, 9'h0FF, {2'b00, 1'b1, 8'hFF, 1'b0}, 10};
    vecs[3] = '{1, 9'h0A5, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};  // even parity of 0xA5 = 0
    vecs[4] = '{2, 9'h0A5, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};  // odd parity of 0xA5 = 1
    vecs[5] = '{1, 9'h001, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11};  // even parity of 0x01 = 1
    vecs[6] = '{2, 9'h000, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11};  // odd parity of 0x00 = 1
    vecs[7] = '{3, 9'h07F, {2'b00, 2'b11, 7'h7F, 1'b0}, 10};
    vecs[8] = '{3, 9'h02A, {2'b00, 2'b11, 7'h2A, 1'b0}, 10};
    vecs[9] = '{4, 9'h0FF, {2'b00, 1'b1, 8'hFF, 1'b0}, 10};      // start bit 2813 cycles low

    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1; tx_valid[i] = 1'b0; tx_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b0;
      check($sformatf("reset_txd_%0d", i), txd_w[i], 1);
      check($sformatf("reset_ready_%0d", i), ready_w[i], 1);
      check($sformatf("reset_busy_%0d", i), busy_w[i], 0);
    end

    for (int i = 0; i < 10; i++)
      send_frame(vecs[i].inst, vecs[i].data, vecs[i].line, vecs[i].nbits, $sformatf("vec%0d", i));

    // Streaming: valid held high, data changed mid-frame; expect two frames
    // separated by exactly one idle-high cycle and no third accept.
    l1 = {1'b1, 8'h55, 1'b0};
    l2 = {1'b1, 8'hAA, 1'b0};
    bad = 0; bad_busy = 0; rdy101 = 1'b0;
    wait_ready(0, "stream");
    tx_data[0]  = 9'h055;
    tx_valid[0] = 1'b1;
    for (int c = 1; c <= 205; c++) begin
      @(negedge clk);
      if (c <= 100)      expb = l1[(c - 1) / 10];
      else if (c == 101) expb = 1'b1;
      else if (c <= 201) expb = l2[(c - 102) / 10];
      else               expb = 1'b1;
      exp_busy = (c != 101) && (c <= 201);
      if (txd_w[0] !== expb) bad++;
      if (busy_w[0] !== exp_busy) bad_busy++;
      if (c == 101) rdy101 = ready_w[0];
      if (c == 1)   tx_data[0] = 9'h0AA;
      if (c == 102) tx_data[0] = 9'h000;
      if (c == 150) tx_valid[0] = 1'b0;
    end
    check("stream_line_errs", bad, 0);
    check("stream_busy_errs", bad_busy, 0);
    check("stream_gap_ready", rdy101, 1);

    // Reset during data bit 3 of 0x00 (line cycles 41..50).
    wait_ready(0, "midrst");
    tx_data[0]  = 9'h000;
    tx_valid[0] = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid[0] = 1'b0;
    end
    check("midrst_txd_before", txd_w[0], 0);
    check("midrst_busy_before", busy_w[0], 1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("midrst_txd_after", txd_w[0], 1);
    check("midrst_busy_after", busy_w[0], 0);
    check("midrst_ready_after", ready_w[0], 1);
    send_frame(0, 9'h03C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
